seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; run-time programmable pattern (1..MAX_LEN bits).
- Selectable overlapping/non-overlapping detection, registered match pulse, saturating match counter.
- Sits on a 1-bit serial stream with a qualifying valid; drop-in successor for the fixed 4-bit "0110" detectors in the lab designs.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LW, 4, width of len_in; must hold MAX_LEN, i.e. clog2(MAX_LEN+1).
- CNT_W, 8, match counter width.
- PAT_DEFAULT, 8'b0000_0110, pattern loaded at reset (LSB-aligned).
- LEN_DEFAULT, 4, pattern length loaded at reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  sync clear of history, counter and cnt_sat.
- pat_load  input  1  load pat_in/len_in into config registers.
- pat_in  input  MAX_LEN  pattern, LSB-aligned; bit len-1 is the first bit expected, bit 0 the last.
- len_in  input  LW  pattern length.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- x_valid  input  1  x is sampled only when high.
- x  input  1  serial data bit.
- z  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  number of matches since reset/clear.
- cnt_sat  output  1  sticky flag: counter reached all-ones.

Behaviour:
- Reset (reset_n low, async): pat=PAT_DEFAULT, len=LEN_DEFAULT, hist=0, fill=0, z=0, match_cnt=0, cnt_sat=0.
- Config load:
  - len_in=0 disables detection; z stays 0.
  - len_in>MAX_LEN is clamped to MAX_LEN.
- State:
  - hist[MAX_LEN-1:0] is a shift register; newest bit enters at bit 0.
  - fill counts valid bits held, 0..len, saturating at len.
- Accept cycle (x_valid=1, no pat_load, no clear):
  - cand = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, len).
  - hit = (len!=0) and (fill_n==len) and (cand[len-1:0]==pat[len-1:0]).
- On hit:
  - z=1 next cycle (latency 1 clk after the completing bit).
  - match_cnt increments unless already all-ones.
  - cnt_sat sets when match_cnt becomes all-ones, and stays set.
- History after hit:
  - overlap_en=1: hist<=cand, fill<=fill_n, so a pattern suffix can start the next match.
  - overlap_en=0: hist<=0, fill<=0.
- No hit: hist<=cand, fill<=fill_n, z=0.
- x_valid=0: hist, fill and counter hold; z=0 (z never stretches).
- pat_load=1:
  - pat/len update; hist and fill clear; z=0 next cycle.
  - Any x accepted that same cycle is discarded.
  - match_cnt is unaffected.
- clear=1: hist, fill, match_cnt and cnt_sat clear; z=0; same-cycle x discarded.
- clear and pat_load together: both take effect.
- Priority: reset_n > clear/pat_load > accept.
- overlap_en is sampled every accept cycle; changing it mid-stream affects only the next hit.
- reset_n asserted mid-stream: all state returns to reset values immediately. First accept is the first rising edge after reset_n deasserts.

Optional Feature:
- Macro SEQ_DETECT_MEALY_OUT_EN.
- Defined:
  - Adds output port z_mealy (1 bit), a combinational copy of hit.
  - z_mealy is high in the same cycle the completing bit is presented with x_valid=1.
  - It is gated low during pat_load/clear.
  - z is unchanged.
- Undefined: port z_mealy and its logic are absent; only registered z exists.

Test Plan:
1. Reset defaults, overlap_en=0; stream x=0,1,1,0 on consecutive valid cycles -> z=1 exactly one cycle after the 4th bit; match_cnt=1.
2. Load pat=0b101, len=3, overlap_en=1; stream 1,0,1,0,1 -> z pulses after bit 3 and bit 5; match_cnt=2.
3. Same pattern, overlap_en=0; stream 1,0,1,0,1 -> single z after bit 3; match_cnt=1.
4. Pattern 0110; stream 0,1 then x_valid=0 for 3 cycles then 1,0 -> z=1 after the final 0. With pat_load asserted during the gap -> no z.
5. CNT_W=2, pattern len=1 value 1; feed 5 valid 1s -> match_cnt stops at 3, cnt_sat=1 from the 3rd match. Then clear -> match_cnt=0, cnt_sat=0.
6. Assert reset_n low mid-pattern (after 0,1,1), release, send 0 -> no z; len_in=0 with any stream -> z never asserts. With SEQ_DETECT_MEALY_OUT_EN: z_mealy leads z by exactly one cycle in scenario 1.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time programmable serial pattern detector with match counter
// Optional combinational z_mealy output when SEQ_DETECT_MEALY_OUT_EN is defined.
module seq_detect_param #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   LW          = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   PAT_DEFAULT = MAX_LEN'(8'b0000_0110),
  parameter int                   LEN_DEFAULT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               overlap_en,
  input  logic               x_valid,
  input  logic               x,
`ifdef SEQ_DETECT_MEALY_OUT_EN
  output logic               z_mealy,
`endif
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;
  logic [LW-1:0]      len_clamp;
  logic               accept;
  logic               hit;

  always_comb begin
    accept    = x_valid & ~pat_load & ~clear;
    cand      = {hist_q[MAX_LEN-2:0], x};
    len_clamp = (len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_in;
    fill_inc  = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
    // Only the low len bits of history take part in the comparison.
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = accept && (len_q != '0) && (fill_inc == len_q) &&
          (((cand ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    z_d    = hit;

    if (accept) begin
      if (hit && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand;
        fill_d = fill_inc;
      end
    end

    if (hit) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end
    end

    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = len_clamp;
      hist_d = '0;
      fill_d = '0;
    end

    // Clear may coincide with pat_load; both apply.
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= PAT_DEFAULT;
      len_q  <= LW'(LEN_DEFAULT);
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

`ifdef SEQ_DETECT_MEALY_OUT_EN
  assign z_mealy = hit;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed scoreboard bench for seq_detect_param
// Checks z_mealy as well when SEQ_DETECT_MEALY_OUT_EN is defined.
module tb_seq_detect_param;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clear;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LW-1:0]      len_in;
  logic               overlap_en;
  logic               x_valid;
  logic               x;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
`ifdef SEQ_DETECT_MEALY_OUT_EN
  logic               z_mealy;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LW(LW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .overlap_en(overlap_en),
    .x_valid(x_valid), .x(x),
`ifdef SEQ_DETECT_MEALY_OUT_EN
    .z_mealy(z_mealy),
`endif
    .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_z(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(z), 32'(e));
    end
  endtask

  // One serial bit; ez is whether this bit completes a match.
  task automatic step(input logic v, input logic b, input logic ez, input string tag);
    @(negedge clk);
    x_valid = v;
    x       = b;
    exp_q.push_back(ez);
`ifdef SEQ_DETECT_MEALY_OUT_EN
    #1 chk({tag, "_mealy"}, 32'(z_mealy), 32'(ez));
`endif
    @(posedge clk);
    #1 pop_z(tag);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic xv, input string tag);
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = p;
    len_in   = l;
    x_valid  = xv;
    x        = 1'b1;
    exp_q.push_back(1'b0);
`ifdef SEQ_DETECT_MEALY_OUT_EN
    #1 chk({tag, "_mealy"}, 32'(z_mealy), 32'd0);
`endif
    @(posedge clk);
    #1 pop_z(tag);
    pat_load = 1'b0;
    x_valid  = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear   = 1'b1;
    x_valid = 1'b1;
    x       = 1'b0;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1 pop_z(tag);
    clear   = 1'b0;
    x_valid = 1'b0;
    chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, "_sat"}, 32'(cnt_sat), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    x_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({tag, "_z"}, 32'(z), 32'd0);
    chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, "_sat"}, 32'(cnt_sat), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; pat_load = 1'b0; pat_in = '0; len_in = '0;
    overlap_en = 1'b0; x_valid = 1'b0; x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: default pattern 0110, non-overlapping
    step(1, 0, 0, "s1_b1"); step(1, 1, 0, "s1_b2");
    step(1, 1, 0, "s1_b3"); step(1, 0, 1, "s1_b4");
    step(0, 0, 0, "s1_nostretch");
    chk("s1_cnt", 32'(match_cnt), 32'd1);
    do_clear("s1_clr");

    // 2: 101 overlapping
    overlap_en = 1'b1;
    load(8'b101, 4'd3, 1'b0, "s2_load");
    step(1, 1, 0, "s2_b1"); step(1, 0, 0, "s2_b2"); step(1, 1, 1, "s2_b3");
    step(1, 0, 0, "s2_b4"); step(1, 1, 1, "s2_b5");
    chk("s2_cnt", 32'(match_cnt), 32'd2);
    do_clear("s2_clr");

    // 3: 101 non-overlapping
    overlap_en = 1'b0;
    step(1, 1, 0, "s3_b1"); step(1, 0, 0, "s3_b2"); step(1, 1, 1, "s3_b3");
    step(1, 0, 0, "s3_b4"); step(1, 1, 0, "s3_b5");
    chk("s3_cnt", 32'(match_cnt), 32'd1);
    do_clear("s3_clr");

    // 4: 0110 with an invalid gap, then with a pattern reload in the gap
    load(8'b0110, 4'd4, 1'b0, "s4_load");
    step(1, 0, 0, "s4_b1"); step(1, 1, 0, "s4_b2");
    step(0, 0, 0, "s4_g1"); step(0, 1, 0, "s4_g2"); step(0, 0, 0, "s4_g3");
    step(1, 1, 0, "s4_b3"); step(1, 0, 1, "s4_b4");
    chk("s4_cnt", 32'(match_cnt), 32'd1);
    step(1, 0, 0, "s4r_b1"); step(1, 1, 0, "s4r_b2");
    load(8'b0110, 4'd4, 1'b1, "s4r_load");
    step(0, 0, 0, "s4r_g1");
    step(1, 1, 0, "s4r_b3"); step(1, 0, 0, "s4r_b4");
    chk("s4r_cnt", 32'(match_cnt), 32'd1);
    do_clear("s4_clr");

    // 5: len 1, counter saturation at 3
    load(8'b1, 4'd1, 1'b0, "s5_load");
    step(1, 1, 1, "s5_m1"); chk("s5_cnt1", 32'(match_cnt), 32'd1); chk("s5_sat1", 32'(cnt_sat), 32'd0);
    step(1, 1, 1, "s5_m2"); chk("s5_cnt2", 32'(match_cnt), 32'd2); chk("s5_sat2", 32'(cnt_sat), 32'd0);
    step(1, 1, 1, "s5_m3"); chk("s5_cnt3", 32'(match_cnt), 32'd3); chk("s5_sat3", 32'(cnt_sat), 32'd1);
    step(1, 1, 1, "s5_m4"); chk("s5_cnt4", 32'(match_cnt), 32'd3); chk("s5_sat4", 32'(cnt_sat), 32'd1);
    step(1, 1, 1, "s5_m5"); chk("s5_cnt5", 32'(match_cnt), 32'd3); chk("s5_sat5", 32'(cnt_sat), 32'd1);
    do_clear("s5_clr");

    // 6a: reset restores the default pattern
    load(8'b101, 4'd3, 1'b0, "s6a_load");
    pulse_reset("s6a_rst");
    step(1, 0, 0, "s6a_b1"); step(1, 1, 0, "s6a_b2");
    step(1, 1, 0, "s6a_b3"); step(1, 0, 1, "s6a_b4");
    chk("s6a_cnt", 32'(match_cnt), 32'd1);

    // 6b: reset mid-pattern discards history
    step(1, 0, 0, "s6b_b1"); step(1, 1, 0, "s6b_b2"); step(1, 1, 0, "s6b_b3");
    pulse_reset("s6b_rst");
    step(1, 0, 0, "s6b_after0");
    step(1, 1, 0, "s6b_c2"); step(1, 1, 0, "s6b_c3"); step(1, 0, 1, "s6b_c4");

    // 6c: len 0 disables detection
    load(8'b0110, 4'd0, 1'b0, "s6c_load");
    for (int r = 0; r < 2; r++) begin
      step(1, 0, 0, "s6c_b1"); step(1, 1, 0, "s6c_b2");
      step(1, 1, 0, "s6c_b3"); step(1, 0, 0, "s6c_b4");
    end
    chk("s6c_cnt", 32'(match_cnt), 32'd1);

    // 7: len 15 clamps to 8
    load(8'hB3, 4'd15, 1'b0, "s7_load");
    step(1, 1, 0, "s7_b1"); step(1, 0, 0, "s7_b2"); step(1, 1, 0, "s7_b3"); step(1, 1, 0, "s7_b4");
    step(1, 0, 0, "s7_b5"); step(1, 0, 0, "s7_b6"); step(1, 1, 0, "s7_b7"); step(1, 1, 1, "s7_b8");
    chk("s7_cnt", 32'(match_cnt), 32'd2);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
